ip_hdr_partial_sum: RTL and testbench

- Stage directly upstream of the checksum-completion stage in the router output-port-lookup pipeline.
- Buffers the 256-bit AXI4-Stream and inspects beat 0 of each packet.
- Produces four 32-bit partial one's-complement sums over the IPv4 header words in beat 0, excluding the header-checksum field, and exports them on checksum01..checksum04.
- The downstream stage completes the sum with the low destination-IP halfword from beat 1. This block also flags header sanity and counts IPv4 and non-IPv4 packets.

---
 rtl/ip_hdr_partial_sum_pkg.sv | 28 ++
 rtl/fallthrough_small_fifo.sv | 57 +++++
 rtl/ip_hdr_sum_calc.sv | 30 +++
 rtl/ip_hdr_partial_sum.sv | 112 +++++++++++
 tb/tb_ip_hdr_partial_sum.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ip_hdr_partial_sum_pkg.sv
// Shared constants for the IPv4 header partial-sum stage: ethertype, header
// halfword byte offsets within beat 0, and the output-side state encoding.
package ip_hdr_partial_sum_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;

  localparam int HW_ETHERTYPE = 12;
  localparam int HW_VER_IHL   = 14;
  localparam int HW_TOT_LEN   = 16;
  localparam int HW_IDENT     = 18;
  localparam int HW_FRAG      = 20;
  localparam int HW_TTL_PROTO = 22;
  localparam int HW_SRC_HI    = 26;
  localparam int HW_SRC_LO    = 28;
  localparam int HW_DST_HI    = 30;

  localparam logic [0:0] HEADER  = 1'b0;
  localparam logic [0:0] PAYLOAD = 1'b1;

  function automatic logic [15:0] get_hw(input logic [255:0] tdata, input int byte_off);
    return tdata[255-8*byte_off -: 16];
  endfunction

  function automatic logic [31:0] hw_sum(input logic [15:0] a, input logic [15:0] b);
    return {16'd0, a} + {16'd0, b};
  endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fallthrough FIFO: dout shows the head entry whenever
// empty is low; nearly_full asserts with one free slot left.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 3
) (
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty,
  input  logic             reset,
  input  logic             clk
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] FULL_CNT = (MAX_DEPTH_BITS+1)'(DEPTH);
  localparam logic [MAX_DEPTH_BITS:0] NF_CNT   = FULL_CNT - 1'b1;

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS:0]   depth;
  logic                      full;
  logic                      wr_ok;
  logic                      rd_ok;

  assign full        = (depth == FULL_CNT);
  assign empty       = (depth == '0);
  assign nearly_full = (depth >= NF_CNT);
  assign rd_ok       = rd_en & ~empty;
  // A push into a full FIFO is safe only when the same edge frees the head slot.
  assign wr_ok       = wr_en & (~full | rd_ok);
  assign dout        = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      depth  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   depth <= depth + 1'b1;
        2'b01:   depth <= depth - 1'b1;
        default: depth <= depth;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ip_hdr_sum_calc.sv
// Combinational map from a beat-0 word to the four IPv4 header partial sums
// (header checksum field excluded) and the header sanity flags.
module ip_hdr_sum_calc
  import ip_hdr_partial_sum_pkg::*;
(
  input  logic [255:0] tdata,
  output logic [31:0]  sum01,
  output logic [31:0]  sum02,
  output logic [31:0]  sum03,
  output logic [31:0]  sum04,
  output logic         hdr_ok,
  output logic         is_ipv4
);

  logic [15:0] ver_ihl;
  logic        unused_bits;

  assign sum01 = hw_sum(get_hw(tdata, HW_VER_IHL),   get_hw(tdata, HW_TOT_LEN));
  assign sum02 = hw_sum(get_hw(tdata, HW_IDENT),     get_hw(tdata, HW_FRAG));
  assign sum03 = hw_sum(get_hw(tdata, HW_TTL_PROTO), get_hw(tdata, HW_SRC_HI));
  assign sum04 = hw_sum(get_hw(tdata, HW_SRC_LO),    get_hw(tdata, HW_DST_HI));

  assign ver_ihl = get_hw(tdata, HW_VER_IHL);
  assign is_ipv4 = (get_hw(tdata, HW_ETHERTYPE) == ETHERTYPE_IPV4);
  assign hdr_ok  = is_ipv4 && (ver_ihl[15:12] == 4'd4) && (ver_ihl[11:8] == 4'd5);

  // MAC addresses and the header checksum halfword never enter the sums.
  assign unused_bits = ^{tdata[255:160], tdata[63:48]};

endmodule

// File: rtl/ip_hdr_partial_sum.sv
// Buffers the AXI4-Stream through a fallthrough FIFO and, on each beat-0 pop,
// registers the IPv4 header partial sums, header sanity and packet counts.
module ip_hdr_partial_sum
  import ip_hdr_partial_sum_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int FIFO_DEPTH_BITS      = 2
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_RESETN,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  input  logic                              S_AXIS_TLAST,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                              M_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY,
  output logic                              M_AXIS_TLAST,
  output logic [31:0]                       checksum01,
  output logic [31:0]                       checksum02,
  output logic [31:0]                       checksum03,
  output logic [31:0]                       checksum04,
  output logic                              hdr_ok,
  output logic [31:0]                       ipv4_count,
  output logic [31:0]                       non_ipv4_count
);

  localparam int FIFO_W = C_M_AXIS_DATA_WIDTH + C_M_AXIS_TUSER_WIDTH + C_M_AXIS_DATA_WIDTH/8 + 1;

  logic              fifo_reset;
  logic              fifo_nearly_full;
  logic              fifo_empty;
  logic              pop;
  logic [0:0]        state;
  logic [31:0]       sum01_p0;
  logic [31:0]       sum02_p0;
  logic [31:0]       sum03_p0;
  logic [31:0]       sum04_p0;
  logic              hdr_ok_p0;
  logic              is_ipv4_p0;
  logic              vld_p0;

  assign fifo_reset    = ~AXI_RESETN;
  assign S_AXIS_TREADY = ~fifo_nearly_full;
  assign M_AXIS_TVALID = ~fifo_empty;
  assign pop           = M_AXIS_TVALID & M_AXIS_TREADY;

  fallthrough_small_fifo #(
    .WIDTH          (FIFO_W),
    .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_in_fifo (
    .din         ({S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TSTRB, S_AXIS_TDATA}),
    .wr_en       (S_AXIS_TVALID & S_AXIS_TREADY),
    .rd_en       (pop),
    .dout        ({M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TSTRB, M_AXIS_TDATA}),
    .nearly_full (fifo_nearly_full),
    .empty       (fifo_empty),
    .reset       (fifo_reset),
    .clk         (AXI_ACLK)
  );

  // Stage p0: header fields of the beat at the FIFO head, qualified by a beat-0 pop
  ip_hdr_sum_calc u_sum_calc (
    .tdata   (M_AXIS_TDATA),
    .sum01   (sum01_p0),
    .sum02   (sum02_p0),
    .sum03   (sum03_p0),
    .sum04   (sum04_p0),
    .hdr_ok  (hdr_ok_p0),
    .is_ipv4 (is_ipv4_p0)
  );

  assign vld_p0 = pop & (state == HEADER);

  // Stage p1: registered sums and counters, held until the next beat-0 pop
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      state          <= HEADER;
      checksum01     <= '0;
      checksum02     <= '0;
      checksum03     <= '0;
      checksum04     <= '0;
      hdr_ok         <= 1'b0;
      ipv4_count     <= '0;
      non_ipv4_count <= '0;
    end else begin
      if (pop) begin
        case (state)
          HEADER:  state <= M_AXIS_TLAST ? HEADER : PAYLOAD;
          default: state <= M_AXIS_TLAST ? HEADER : PAYLOAD;
        endcase
      end
      if (vld_p0) begin
        checksum01 <= sum01_p0;
        checksum02 <= sum02_p0;
        checksum03 <= sum03_p0;
        checksum04 <= sum04_p0;
        hdr_ok     <= hdr_ok_p0;
        if (is_ipv4_p0) ipv4_count     <= ipv4_count + 32'd1;
        else            non_ipv4_count <= non_ipv4_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_ip_hdr_partial_sum.sv
// Bench for ip_hdr_partial_sum: directed packets plus randomized traffic,
// compared against a byte-level reference model and a beat scoreboard.
module tb_ip_hdr_partial_sum;

  logic         AXI_ACLK = 1'b0;
  logic         AXI_RESETN;
  logic [255:0] S_AXIS_TDATA;
  logic [31:0]  S_AXIS_TSTRB;
  logic [127:0] S_AXIS_TUSER;
  logic         S_AXIS_TVALID;
  logic         S_AXIS_TREADY;
  logic         S_AXIS_TLAST;
  logic [255:0] M_AXIS_TDATA;
  logic [31:0]  M_AXIS_TSTRB;
  logic [127:0] M_AXIS_TUSER;
  logic         M_AXIS_TVALID;
  logic         M_AXIS_TREADY;
  logic         M_AXIS_TLAST;
  logic [31:0]  checksum01, checksum02, checksum03, checksum04;
  logic         hdr_ok;
  logic [31:0]  ipv4_count, non_ipv4_count;

  always #5 AXI_ACLK = ~AXI_ACLK;

  ip_hdr_partial_sum dut (
    .AXI_ACLK       (AXI_ACLK),
    .AXI_RESETN     (AXI_RESETN),
    .S_AXIS_TDATA   (S_AXIS_TDATA),
    .S_AXIS_TSTRB   (S_AXIS_TSTRB),
    .S_AXIS_TUSER   (S_AXIS_TUSER),
    .S_AXIS_TVALID  (S_AXIS_TVALID),
    .S_AXIS_TREADY  (S_AXIS_TREADY),
    .S_AXIS_TLAST   (S_AXIS_TLAST),
    .M_AXIS_TDATA   (M_AXIS_TDATA),
    .M_AXIS_TSTRB   (M_AXIS_TSTRB),
    .M_AXIS_TUSER   (M_AXIS_TUSER),
    .M_AXIS_TVALID  (M_AXIS_TVALID),
    .M_AXIS_TREADY  (M_AXIS_TREADY),
    .M_AXIS_TLAST   (M_AXIS_TLAST),
    .checksum01     (checksum01),
    .checksum02     (checksum02),
    .checksum03     (checksum03),
    .checksum04     (checksum04),
    .hdr_ok         (hdr_ok),
    .ipv4_count     (ipv4_count),
    .non_ipv4_count (non_ipv4_count)
  );

  typedef struct packed {
    logic [255:0] d;
    logic [127:0] u;
    logic [31:0]  s;
    logic         l;
  } beat_t;

  beat_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 0;
  bit          in_pkt = 0;
  bit          rand_rdy = 0;
  logic [31:0] e_c1 = 0, e_c2 = 0, e_c3 = 0, e_c4 = 0, e_ipv4 = 0, e_non = 0;
  logic        e_ok = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: header viewed as a byte array, halfword = two consecutive bytes.
  function automatic logic [15:0] ref_hw(input logic [255:0] d, input int off);
    logic [7:0] b [32];
    for (int k = 0; k < 32; k++) b[k] = d[255-8*k -: 8];
    return {b[off], b[off+1]};
  endfunction

  function automatic logic [31:0] ref_sum(input logic [255:0] d, input int a, input int b);
    return 32'(ref_hw(d, a)) + 32'(ref_hw(d, b));
  endfunction

  task automatic ref_update(input logic [255:0] d);
    logic [15:0] eth, vi;
    eth  = ref_hw(d, 12);
    vi   = ref_hw(d, 14);
    e_c1 = ref_sum(d, 14, 16);
    e_c2 = ref_sum(d, 18, 20);
    e_c3 = ref_sum(d, 22, 26);
    e_c4 = ref_sum(d, 28, 30);
    e_ok = (eth == 16'h0800) && (vi[15:8] == 8'h45);
    if (eth == 16'h0800) e_ipv4 = e_ipv4 + 32'd1;
    else                 e_non  = e_non + 32'd1;
  endtask

  function automatic logic [255:0] rand256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [255:0] mk_beat0(input logic [15:0] eth, input bit good);
    logic [255:0] d;
    d = rand256();
    d[159:144] = eth;
    if (good) d[143:136] = 8'h45;
    return d;
  endfunction

  function automatic beat_t mk(input logic [255:0] d, input logic last);
    beat_t b;
    b.d = d;
    b.u = {$urandom(), $urandom(), $urandom(), $urandom()};
    b.s = $urandom();
    b.l = last;
    return b;
  endfunction

  always @(negedge AXI_ACLK) begin
    beat_t b;
    if (mon_en) begin
      chk("checksum01", 256'(checksum01), 256'(e_c1));
      chk("checksum02", 256'(checksum02), 256'(e_c2));
      chk("checksum03", 256'(checksum03), 256'(e_c3));
      chk("checksum04", 256'(checksum04), 256'(e_c4));
      chk("hdr_ok", 256'(hdr_ok), 256'(e_ok));
      chk("ipv4_count", 256'(ipv4_count), 256'(e_ipv4));
      chk("non_ipv4_count", 256'(non_ipv4_count), 256'(e_non));
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 256'(M_AXIS_TVALID), 256'(0));
        end else begin
          b = exp_q.pop_front();
          chk("m_tdata", M_AXIS_TDATA, b.d);
          chk("m_tuser", 256'(M_AXIS_TUSER), 256'(b.u));
          chk("m_tstrb", 256'(M_AXIS_TSTRB), 256'(b.s));
          chk("m_tlast", 256'(M_AXIS_TLAST), 256'(b.l));
          if (!in_pkt) ref_update(b.d);
          in_pkt = !b.l;
        end
      end
    end
  end

  task automatic send_beat(input beat_t b);
    bit accepted;
    accepted      = 0;
    S_AXIS_TDATA  = b.d;
    S_AXIS_TUSER  = b.u;
    S_AXIS_TSTRB  = b.s;
    S_AXIS_TLAST  = b.l;
    S_AXIS_TVALID = 1'b1;
    for (int n = 0; n < 200 && !accepted; n++) begin
      @(negedge AXI_ACLK);
      if (S_AXIS_TREADY) begin
        exp_q.push_back(b);
        accepted = 1;
      end
      @(posedge AXI_ACLK); #1;
      if (rand_rdy) M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
    end
    chk("s_ready_timeout", 256'(accepted), 256'(1));
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge AXI_ACLK);
      if (exp_q.size() == 0 && !M_AXIS_TVALID) done = 1;
    end
    chk("drain_timeout", 256'(done), 256'(1));
    @(posedge AXI_ACLK); #1;
  endtask

  task automatic clear_model();
    e_c1 = 0; e_c2 = 0; e_c3 = 0; e_c4 = 0; e_ok = 0;
    e_ipv4 = 0; e_non = 0; in_pkt = 0;
    exp_q.delete();
  endtask

  initial begin
    logic [255:0] p1, d0, d1;
    logic [31:0]  held;
    S_AXIS_TDATA = '0; S_AXIS_TUSER = '0; S_AXIS_TSTRB = '0;
    S_AXIS_TLAST = 0; S_AXIS_TVALID = 0; M_AXIS_TREADY = 1; AXI_RESETN = 0;
    repeat (3) @(posedge AXI_ACLK); #1;
    chk("rst_m_tvalid", 256'(M_AXIS_TVALID), 256'(0));
    chk("rst_checksum01", 256'(checksum01), 256'(0));
    chk("rst_hdr_ok", 256'(hdr_ok), 256'(0));
    chk("rst_ipv4_count", 256'(ipv4_count), 256'(0));
    chk("rst_non_ipv4_count", 256'(non_ipv4_count), 256'(0));
    AXI_RESETN = 1;
    @(negedge AXI_ACLK);
    chk("rst_s_tready", 256'(S_AXIS_TREADY), 256'(1));
    clear_model();
    mon_en = 1;
    @(posedge AXI_ACLK); #1;

    // Known IPv4 header, checksum halfword b1e6 skipped
    p1 = {96'h0011_2233_4455_6677_8899_aabb, 16'h0800,
          144'h4500_0054_1c46_4000_4006_b1e6_ac10_0a63_ac10};
    send_beat(mk(p1, 1'b0));
    S_AXIS_TVALID = 0;
    @(negedge AXI_ACLK);
    chk("latency_m_tvalid", 256'(M_AXIS_TVALID), 256'(1));
    chk("pre_pop_checksum01", 256'(checksum01), 256'(0));
    @(negedge AXI_ACLK);
    chk("vec_checksum01", 256'(checksum01), 256'(32'h0000_4554));
    chk("vec_checksum02", 256'(checksum02), 256'(32'h0000_5c46));
    chk("vec_checksum03", 256'(checksum03), 256'(32'h0000_ec16));
    chk("vec_checksum04", 256'(checksum04), 256'(32'h0000_b673));
    chk("vec_hdr_ok", 256'(hdr_ok), 256'(1));
    chk("vec_ipv4_count", 256'(ipv4_count), 256'(1));
    @(posedge AXI_ACLK); #1;
    send_beat(mk(rand256(), 1'b0));
    send_beat(mk(rand256(), 1'b1));
    S_AXIS_TVALID = 0;
    drain();
    chk("vec_hold_checksum03", 256'(checksum03), 256'(32'h0000_ec16));

    // ARP packet
    send_beat(mk(mk_beat0(16'h0806, 1), 1'b0));
    send_beat(mk(rand256(), 1'b1));
    S_AXIS_TVALID = 0;
    drain();
    chk("arp_hdr_ok", 256'(hdr_ok), 256'(0));
    chk("arp_non_ipv4", 256'(non_ipv4_count), 256'(1));
    chk("arp_ipv4", 256'(ipv4_count), 256'(1));

    // Single-beat IPv4 packet immediately followed by a 2-beat packet
    d0 = mk_beat0(16'h0800, 1);
    d1 = mk_beat0(16'h0800, 1);
    send_beat(mk(d0, 1'b1));
    send_beat(mk(d1, 1'b0));
    send_beat(mk(rand256(), 1'b1));
    S_AXIS_TVALID = 0;
    drain();
    chk("single_ipv4_count", 256'(ipv4_count), 256'(3));
    chk("single_checksum01", 256'(checksum01), 256'(ref_sum(d1, 14, 16)));
    chk("single_checksum04", 256'(checksum04), 256'(ref_sum(d1, 28, 30)));

    // Output stalled for 10 cycles while an 8-beat packet is offered
    held = checksum01;
    d0 = mk_beat0(16'h0800, 1);
    M_AXIS_TREADY = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_beat(mk((i == 0) ? d0 : rand256(), i == 7));
        S_AXIS_TVALID = 0;
      end
      begin
        repeat (6) @(negedge AXI_ACLK);
        chk("bp_s_tready", 256'(S_AXIS_TREADY), 256'(0));
        chk("bp_beats_accepted", 256'(exp_q.size()), 256'(3));
        chk("bp_m_tvalid", 256'(M_AXIS_TVALID), 256'(1));
        chk("bp_checksum_held", 256'(checksum01), 256'(held));
        repeat (4) @(negedge AXI_ACLK);
        @(posedge AXI_ACLK); #1;
        M_AXIS_TREADY = 1;
      end
    join
    drain();
    chk("bp_ipv4_count", 256'(ipv4_count), 256'(4));
    chk("bp_checksum02", 256'(checksum02), 256'(ref_sum(d0, 18, 20)));

    // Asynchronous reset while beat 2 is offered
    send_beat(mk(mk_beat0(16'h0800, 1), 1'b0));
    send_beat(mk(rand256(), 1'b0));
    mon_en = 0;
    S_AXIS_TDATA = rand256();
    S_AXIS_TLAST = 1;
    #2;
    AXI_RESETN = 0;
    #1;
    chk("arst_checksum01", 256'(checksum01), 256'(0));
    chk("arst_checksum03", 256'(checksum03), 256'(0));
    chk("arst_hdr_ok", 256'(hdr_ok), 256'(0));
    chk("arst_ipv4_count", 256'(ipv4_count), 256'(0));
    chk("arst_m_tvalid", 256'(M_AXIS_TVALID), 256'(0));
    chk("arst_s_tready", 256'(S_AXIS_TREADY), 256'(1));
    S_AXIS_TVALID = 0;
    clear_model();
    @(negedge AXI_ACLK);
    AXI_RESETN = 1;
    @(posedge AXI_ACLK); #1;
    mon_en = 1;
    d0 = mk_beat0(16'h0800, 1);
    send_beat(mk(d0, 1'b0));
    send_beat(mk(rand256(), 1'b0));
    send_beat(mk(rand256(), 1'b1));
    S_AXIS_TVALID = 0;
    drain();
    chk("post_rst_ipv4_count", 256'(ipv4_count), 256'(1));
    chk("post_rst_checksum03", 256'(checksum03), 256'(ref_sum(d0, 22, 26)));

    // Counter wrap from all-ones
    mon_en = 0;
    force dut.ipv4_count = 32'hFFFF_FFFF;
    @(negedge AXI_ACLK);
    release dut.ipv4_count;
    e_ipv4 = 32'hFFFF_FFFF;
    chk("preload_ipv4_count", 256'(ipv4_count), 256'(32'hFFFF_FFFF));
    @(posedge AXI_ACLK); #1;
    mon_en = 1;
    send_beat(mk(mk_beat0(16'h0800, 1), 1'b0));
    send_beat(mk(rand256(), 1'b1));
    S_AXIS_TVALID = 0;
    drain();
    chk("wrap_ipv4_count", 256'(ipv4_count), 256'(0));

    // Randomized packets with random output backpressure and input gaps
    rand_rdy = 1;
    for (int p = 0; p < 25; p++) begin
      int len, kind;
      logic [15:0] eth;
      len  = $urandom_range(1, 4);
      kind = $urandom_range(0, 3);
      eth  = (kind == 2) ? 16'h0806 : (kind == 3) ? 16'($urandom()) : 16'h0800;
      for (int i = 0; i < len; i++) begin
        send_beat(mk((i == 0) ? mk_beat0(eth, kind == 0) : rand256(), i == len - 1));
        if ($urandom_range(0, 3) == 0) begin
          S_AXIS_TVALID = 0;
          @(posedge AXI_ACLK); #1;
        end
      end
    end
    S_AXIS_TVALID = 0;
    rand_rdy = 0;
    M_AXIS_TREADY = 1;
    drain();
    chk("rand_ipv4_count", 256'(ipv4_count), 256'(e_ipv4));
    chk("rand_non_ipv4_count", 256'(non_ipv4_count), 256'(e_non));

    mon_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
